// File: rtl/uart_regfile_access_ctrl.sv
// Access sequencer for the UART 4-entry register file: round-robin arbitration between
// host bus accesses and core status-set requests, with read-modify-write for W1C/set.
module uart_regfile_access_ctrl #(
    parameter int         N           = 4,
    parameter logic [1:0] STATUS_ADDR = 2'd1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         host_req,
    input  logic         host_we,
    input  logic [1:0]   host_addr,
    input  logic [N-1:0] host_wdata,
    output logic         host_ack,
    output logic [N-1:0] host_rdata,
    input  logic         core_set_req,
    input  logic [N-1:0] core_set_bits,
    output logic         core_set_ack,
    output logic         rf_rwa0,
    output logic         rf_rwa1,
    output logic         rf_wren,
    output logic [N-1:0] rf_wdata,
    input  logic [N-1:0] rf_rdata
);

    typedef enum logic [2:0] {IDLE, HOST_WR, HOST_RD, RMW_RD, RMW_WR, DONE} state_t;

    state_t       state, state_nxt;
    logic         gnt_core, gnt_core_nxt;
    logic         op_set, op_set_nxt;
    logic         last_core, last_core_nxt;
    logic [N-1:0] tmp;
    logic [1:0]   addr;

    assign rf_rwa0 = addr[0];
    assign rf_rwa1 = addr[1];

    always_comb begin
        state_nxt     = state;
        gnt_core_nxt  = gnt_core;
        op_set_nxt    = op_set;
        last_core_nxt = last_core;
        addr          = 2'b00;
        rf_wren       = 1'b0;
        rf_wdata      = '0;
        case (state)
            IDLE: begin
                // last_grant only moves on a true tie, so a lone request never steals priority
                if (core_set_req && (!host_req || !last_core)) begin
                    gnt_core_nxt = 1'b1;
                    op_set_nxt   = 1'b1;
                    state_nxt    = RMW_RD;
                    if (host_req) last_core_nxt = 1'b1;
                end else if (host_req) begin
                    gnt_core_nxt = 1'b0;
                    op_set_nxt   = 1'b0;
                    if (core_set_req) last_core_nxt = 1'b0;
                    if (!host_we)                      state_nxt = HOST_RD;
                    else if (host_addr == STATUS_ADDR) state_nxt = RMW_RD;
                    else                               state_nxt = HOST_WR;
                end
            end
            HOST_WR: begin
                addr      = host_addr;
                rf_wren   = 1'b1;
                rf_wdata  = host_wdata;
                state_nxt = DONE;
            end
            HOST_RD: begin
                addr      = host_addr;
                state_nxt = DONE;
            end
            RMW_RD: begin
                addr      = STATUS_ADDR;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                addr      = STATUS_ADDR;
                rf_wren   = 1'b1;
                rf_wdata  = op_set ? (tmp | core_set_bits) : (tmp & ~host_wdata);
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= IDLE;
            gnt_core     <= 1'b0;
            op_set       <= 1'b0;
            last_core    <= 1'b0;
            tmp          <= '0;
            host_rdata   <= '0;
            host_ack     <= 1'b0;
            core_set_ack <= 1'b0;
        end else begin
            state        <= state_nxt;
            gnt_core     <= gnt_core_nxt;
            op_set       <= op_set_nxt;
            last_core    <= last_core_nxt;
            if (state == HOST_RD) host_rdata <= rf_rdata;
            if (state == RMW_RD)  tmp        <= rf_rdata;
            host_ack     <= (state_nxt == DONE) && (state != DONE) && !gnt_core_nxt;
            core_set_ack <= (state_nxt == DONE) && (state != DONE) &&  gnt_core_nxt;
        end
    end

endmodule

// File: tb/tb_uart_regfile_access_ctrl.sv
// Bench for uart_regfile_access_ctrl: behavioural register file, vector table of single
// transactions, and directed sequences for reset, simultaneous requests and mid-RMW reset.
module tb_uart_regfile_access_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [1:0] host_addr = 2'd0;
    logic [3:0] host_wdata = 4'd0;
    logic       host_ack;
    logic [3:0] host_rdata;
    logic       core_set_req = 1'b0;
    logic [3:0] core_set_bits = 4'd0;
    logic       core_set_ack;
    logic       rf_rwa0, rf_rwa1, rf_wren;
    logic [3:0] rf_wdata, rf_rdata;

    logic [3:0] mem [4];
    int         wren_total = 0;
    int         n_checks = 0, n_pass = 0;

    always #5 CLK = ~CLK;

    uart_regfile_access_ctrl #(.N(4), .STATUS_ADDR(2'd1)) dut (
        .CLK(CLK), .RST(RST),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .core_set_req(core_set_req), .core_set_bits(core_set_bits),
        .core_set_ack(core_set_ack),
        .rf_rwa0(rf_rwa0), .rf_rwa1(rf_rwa1), .rf_wren(rf_wren),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file model: combinational read, write on rising edge
    assign rf_rdata = mem[{rf_rwa1, rf_rwa0}];
    always @(posedge CLK) begin
        if (rf_wren) begin
            mem[{rf_rwa1, rf_rwa0}] <= rf_wdata;
            wren_total <= wren_total + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic       core;
        logic       we;
        logic [1:0] addr;
        logic [3:0] data;
        int         exp_lat;
        int         exp_wren;
        logic [1:0] exp_rwa;
        logic [3:0] exp_val;
    } vec_t;

    task automatic run_txn(input vec_t v, input int idx);
        int         lat = 0, wren_n = 0;
        logic [3:0] wd = 4'hx;
        logic [1:0] rwa = 2'bxx;
        logic       wrong = 1'b0, done = 1'b0;
        @(negedge CLK);
        if (v.core) begin
            core_set_req = 1'b1; core_set_bits = v.data;
        end else begin
            host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.data;
        end
        while (!done && lat < 20) begin
            @(negedge CLK);
            lat++;
            if (rf_wren) begin wren_n++; wd = rf_wdata; rwa = {rf_rwa1, rf_rwa0}; end
            if (v.core ? host_ack : core_set_ack) wrong = 1'b1;
            if (v.core ? core_set_ack : host_ack) done = 1'b1;
        end
        host_req = 1'b0;
        core_set_req = 1'b0;
        chk($sformatf("v%0d ack latency", idx), done ? lat : -1, v.exp_lat);
        chk($sformatf("v%0d wren cycles", idx), wren_n, v.exp_wren);
        chk($sformatf("v%0d wrong ack", idx), int'(wrong), 0);
        if (v.exp_wren != 0) begin
            chk($sformatf("v%0d wdata", idx), int'(wd), int'(v.exp_val));
            chk($sformatf("v%0d wr addr", idx), int'(rwa), int'(v.exp_rwa));
        end else begin
            chk($sformatf("v%0d rdata", idx), int'(host_rdata), int'(v.exp_val));
        end
    endtask

    // Both requesters raise together; records the cycle each ack is seen
    task automatic run_tie(input string tag, input logic hwe, input logic [1:0] haddr,
                           input logic [3:0] hdata, input logic [3:0] cbits,
                           input int exp_host_t, input int exp_core_t);
        int   cyc = 0, host_t = 0, core_t = 0;
        logic overlap = 1'b0;
        @(negedge CLK);
        host_req = 1'b1; host_we = hwe; host_addr = haddr; host_wdata = hdata;
        core_set_req = 1'b1; core_set_bits = cbits;
        while ((host_t == 0 || core_t == 0) && cyc < 30) begin
            @(negedge CLK);
            cyc++;
            if (host_ack && core_set_ack) overlap = 1'b1;
            if (host_ack && host_t == 0) begin host_t = cyc; host_req = 1'b0; end
            if (core_set_ack && core_t == 0) begin core_t = cyc; core_set_req = 1'b0; end
        end
        host_req = 1'b0;
        core_set_req = 1'b0;
        chk({tag, " ack overlap"}, int'(overlap), 0);
        chk({tag, " host ack cycle"}, host_t, exp_host_t);
        chk({tag, " core ack cycle"}, core_t, exp_core_t);
    endtask

    vec_t vecs [10];
    int   wren_before;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 4'h0;
        //            core  we    addr   data     lat wren rwa    val
        vecs[0] = '{1'b0, 1'b1, 2'd2, 4'hA,     2, 1, 2'b10, 4'hA};
        vecs[1] = '{1'b0, 1'b0, 2'd2, 4'h0,     2, 0, 2'b00, 4'hA};
        vecs[2] = '{1'b0, 1'b1, 2'd1, 4'hF,     3, 1, 2'b01, 4'h0};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 4'b1011,  3, 1, 2'b01, 4'b1011};
        vecs[4] = '{1'b0, 1'b1, 2'd1, 4'b0011,  3, 1, 2'b01, 4'b1000};
        vecs[5] = '{1'b0, 1'b0, 2'd1, 4'h0,     2, 0, 2'b00, 4'b1000};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 4'b0100,  3, 1, 2'b01, 4'b1100};
        vecs[7] = '{1'b0, 1'b0, 2'd3, 4'h0,     2, 0, 2'b00, 4'h5};
        vecs[8] = '{1'b0, 1'b1, 2'd0, 4'h7,     2, 1, 2'b00, 4'h7};
        vecs[9] = '{1'b0, 1'b0, 2'd1, 4'h0,     2, 0, 2'b00, 4'b1100};

        // Reset with both requests pending
        RST = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 2'd3; host_wdata = 4'h5;
        core_set_req = 1'b1; core_set_bits = 4'b0001;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset host_ack", int'(host_ack), 0);
        chk("reset core_set_ack", int'(core_set_ack), 0);
        chk("reset rf_wren", int'(rf_wren), 0);
        chk("reset host_rdata", int'(host_rdata), 0);
        chk("reset rf_wdata", int'(rf_wdata), 0);
        chk("reset rf_rwa", int'({rf_rwa1, rf_rwa0}), 0);
        host_req = 1'b0; core_set_req = 1'b0;
        RST = 1'b1;

        // First tie: core (set 0001) wins, then host write addr 3 = 5
        run_tie("tie1", 1'b1, 2'd3, 4'h5, 4'b0001, 6, 3);
        chk("tie1 status", int'(mem[1]), 1);
        chk("tie1 reg3", int'(mem[3]), 5);

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Second tie: host read of addr 2 goes first, core sets 0001 after
        run_tie("tie2", 1'b0, 2'd2, 4'h0, 4'b0001, 2, 6);
        chk("tie2 rdata", int'(host_rdata), 4'hA);
        chk("tie2 status", int'(mem[1]), 4'b1101);

        // Reset during RMW_RD of a host W1C
        wren_before = wren_total;
        @(negedge CLK);
        host_req = 1'b1; host_we = 1'b1; host_addr = 2'd1; host_wdata = 4'hF;
        @(negedge CLK);
        chk("midrmw rd addr", int'({rf_rwa1, rf_rwa0}), 1);
        chk("midrmw rd wren", int'(rf_wren), 0);
        RST = 1'b0;
        @(negedge CLK);
        host_req = 1'b0;
        chk("midrmw post wren", int'(rf_wren), 0);
        chk("midrmw post rwa", int'({rf_rwa1, rf_rwa0}), 0);
        chk("midrmw post wdata", int'(rf_wdata), 0);
        chk("midrmw post acks", int'({host_ack, core_set_ack}), 0);
        chk("midrmw post rdata", int'(host_rdata), 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrmw wren count", wren_total - wren_before, 0);
        chk("midrmw status kept", int'(mem[1]), 4'b1101);
        run_txn('{1'b0, 1'b0, 2'd1, 4'h0, 2, 0, 2'b00, 4'b1101}, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_regfile_access_ctrl.md
Name: uart_regfile_access_ctrl

Overview:
- Sequences every access to the UART 4-entry register file: TXFIFO at address 0, W1CSTATUS at 1, CONTROL at 2, BRD at 3.
- Shares the file's single write port and read mux between the host bus and the UART core's status-set requests, using round-robin arbitration.
- Implements write-1-to-clear on the status register by read-modify-write, and a core status-bit "set" operation by read-modify-write.
- Sits between the host interface and the register file, and drives the file's RWA0, RWA1, WrEn and writeData pins directly.

Parameters:
- N, 4, register data width; must match the register file width.
- STATUS_ADDR, 2'd1, address of the W1C status register.

Ports:
- CLK  input  1  clock; all logic is rising-edge.
- RST  input  1  synchronous, active-low reset.
- host_req  input  1  host access request; held high until host_ack is seen.
- host_we  input  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  input  2  register address; stable while host_req is high.
- host_wdata  input  N  write data, or clear mask for STATUS_ADDR.
- host_ack  output  1  one-cycle completion pulse.
- host_rdata  output  N  read data; valid in the host_ack cycle and held until the next read completes.
- core_set_req  input  1  core request to OR bits into the status register; held high until core_set_ack.
- core_set_bits  input  N  bits to set; stable while core_set_req is high.
- core_set_ack  output  1  one-cycle completion pulse.
- rf_rwa0  output  1  register file address bit 0.
- rf_rwa1  output  1  register file address bit 1.
- rf_wren  output  1  register file write enable.
- rf_wdata  output  N  register file write data.
- rf_rdata  input  N  register file read data (combinational from rf_rwa1:rf_rwa0).

Behaviour:
- Reset (RST=0 at a rising edge):
  - State goes to IDLE.
  - host_ack, core_set_ack, rf_wren, rf_rwa0, rf_rwa1 = 0; rf_wdata = 0; host_rdata = 0.
  - Internal tmp register = 0; last_grant = HOST, so the core wins the first tie.
  - Reset overrides any state, including mid-RMW: no rf_wren is issued in the cycle after reset is sampled.
- States: IDLE, HOST_WR, HOST_RD, RMW_RD, RMW_WR, DONE.
- IDLE:
  - rf_wren = 0; rf_rwa* = 0.
  - If exactly one request is high, grant it.
  - If both are high, grant the opposite of last_grant, then update last_grant.
  - On a host grant:
    - host_we=1 and host_addr != STATUS_ADDR -> HOST_WR.
    - host_we=0 -> HOST_RD.
    - host_we=1 and host_addr == STATUS_ADDR -> RMW_RD, op = CLEAR.
  - On a core grant: -> RMW_RD, op = SET.
- HOST_WR (1 cycle):
  - rf_rwa1:rf_rwa0 = host_addr, rf_wren = 1, rf_wdata = host_wdata.
  - Next state DONE.
- HOST_RD (1 cycle):
  - rf_rwa1:rf_rwa0 = host_addr, rf_wren = 0.
  - host_rdata <= rf_rdata at the end of the cycle.
  - Next state DONE.
- RMW_RD (1 cycle):
  - rf_rwa1:rf_rwa0 = STATUS_ADDR, rf_wren = 0.
  - tmp <= rf_rdata.
  - Next state RMW_WR.
- RMW_WR (1 cycle):
  - rf_rwa1:rf_rwa0 = STATUS_ADDR, rf_wren = 1.
  - rf_wdata = tmp & ~host_wdata for CLEAR; tmp | core_set_bits for SET.
  - Next state DONE.
- DONE (1 cycle):
  - host_ack = 1 or core_set_ack = 1, according to the granted requester; rf_wren = 0.
  - Requests are not sampled in this state. The requester deasserts its req at the edge ending DONE.
  - Next state IDLE.
- host_ack and core_set_ack are registered, never both high, and never high outside DONE.
- Latency from request sampled in IDLE to ack:
  - Plain write or read: 2 cycles after the grant edge (access cycle, then DONE).
  - RMW: 3 cycles.
- Exactly one rf_wren cycle per write or RMW; zero for reads.
- A request held through another requester's transaction is granted at the next IDLE. Round-robin guarantees service within one competing transaction.
- A host read of STATUS_ADDR is a plain read; no side effect.
- Width rules: bitwise operations only, all N bits wide; no carries.

Test Plan:
- Hold RST=0 for 2 cycles with both requests high -> host_ack = core_set_ack = rf_wren = 0, host_rdata = 0. With RST back at 1, the first grant goes to the core.
- Host write addr 2, data 4'hA:
  - Expect rf_wren high for exactly one cycle with rf_rwa1=1, rf_rwa0=0, rf_wdata=4'hA.
  - Expect host_ack on the next cycle.
  - A following host read of addr 2 gives host_rdata = 4'hA in its ack cycle.
- Core set 4'b1011 on status 0 -> status becomes 1011. Host write addr 1, mask 4'b0011 -> RMW writes 4'b1000, and a host read of addr 1 returns 1000.
- Core set 4'b0100 on status 1000 -> rf_wdata = 1100 with rf_rwa=01. core_set_ack is pulsed once, 3 cycles after the grant.
- host_req and core_set_req rise together after reset -> core served first and host second, with no overlap of acks. On the next simultaneous pair, host is served first.
- Assert RST=0 during RMW_RD of a host W1C -> no rf_wren follows, status is unchanged, and all outputs are 0 on the next cycle.
